// File: rtl/lane_deskew_fifo_pkg.sv
// Shared definitions for the per-lane deskew stage: block width, skew limit and FSM encoding.
package lane_deskew_fifo_pkg;

    localparam int NB_CODED_BLOCK = 66;
    localparam int MAX_SKEW       = 32;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WAIT_SOL = 3'd1,
        ST_COUNT    = 3'd2,
        ST_LOCKED   = 3'd3,
        ST_OVERFLOW = 3'd4
    } deskew_state_t;

endpackage

// File: rtl/lane_deskew_fifo_buffer_ram.sv
// Simple dual-port circular buffer holding {sol, block}; synchronous read with write-first bypass.
module deskew_buffer_ram #(
    parameter int NB_DATA = 67,
    parameter int NB_ADDR = 6
) (
    input  logic               i_clock,
    input  logic               i_reset,
    input  logic               i_wr_en,
    input  logic [NB_ADDR-1:0] i_waddr,
    input  logic [NB_DATA-1:0] i_wdata,
    input  logic               i_rd_en,
    input  logic [NB_ADDR-1:0] i_raddr,
    output logic [NB_DATA-1:0] o_rdata
);

    logic [NB_DATA-1:0] mem [0:(1<<NB_ADDR)-1];

    always_ff @(posedge i_clock) begin
        if (i_wr_en) begin
            mem[i_waddr] <= i_wdata;
        end
    end

    // A zero read delay addresses the slot being written this cycle, so forward the incoming word.
    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_rdata <= '0;
        end else if (i_rd_en) begin
            o_rdata <= (i_wr_en && (i_raddr == i_waddr)) ? i_wdata : mem[i_raddr];
        end
    end

endmodule

// File: rtl/lane_deskew_fifo.sv
// Per-lane deskew: measures how far this lane's SOL leads the last lane's and replays blocks delayed by that count.
module lane_deskew_fifo
    import lane_deskew_fifo_pkg::*;
#(
    parameter int NB_CODED_BLOCK = lane_deskew_fifo_pkg::NB_CODED_BLOCK,
    parameter int MAX_SKEW       = lane_deskew_fifo_pkg::MAX_SKEW,
    parameter int NB_ADDR        = 6,
    parameter int NB_DELAY       = 6
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic                      i_rf_enable,
    input  logic                      i_valid,
    input  logic                      i_am_lock,
    input  logic                      i_resync,
    input  logic                      i_start_of_lane,
    input  logic [NB_CODED_BLOCK-1:0] i_data,
    input  logic                      i_all_sol,
    output logic [NB_CODED_BLOCK-1:0] o_data,
    output logic                      o_valid,
    output logic                      o_start_of_lane,
    output logic                      o_deskew_done,
    output logic                      o_skew_overflow,
    output logic [NB_DELAY-1:0]       o_delay
);

    deskew_state_t       state;
    deskew_state_t       state_next;
    logic [NB_DELAY-1:0] cnt;
    logic [NB_DELAY-1:0] cnt_next;
    logic [NB_DELAY-1:0] delay;
    logic [NB_DELAY-1:0] delay_next;
    logic [NB_ADDR-1:0]  wr_ptr;
    logic [NB_ADDR-1:0]  rd_addr;
    logic                advance;

    assign advance = i_rf_enable & i_valid;

    // Lock loss is honoured on any enabled clock; everything else only moves on a valid block.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        delay_next = delay;
        if (i_rf_enable) begin
            if (!i_am_lock) begin
                state_next = ST_IDLE;
                cnt_next   = '0;
                delay_next = '0;
            end else if (i_valid) begin
                if (i_resync) begin
                    state_next = ST_WAIT_SOL;
                    cnt_next   = '0;
                    delay_next = '0;
                end else begin
                    case (state)
                        ST_IDLE: begin
                            state_next = ST_WAIT_SOL;
                        end
                        ST_WAIT_SOL: begin
                            if (i_start_of_lane) begin
                                if (i_all_sol) begin
                                    state_next = ST_LOCKED;
                                    delay_next = '0;
                                end else begin
                                    state_next = ST_COUNT;
                                    cnt_next   = NB_DELAY'(1);
                                end
                            end
                        end
                        ST_COUNT: begin
                            if (i_all_sol) begin
                                state_next = ST_LOCKED;
                                delay_next = cnt;
                            end else if (cnt == NB_DELAY'(MAX_SKEW)) begin
                                state_next = ST_OVERFLOW;
                                delay_next = '0;
                            end else begin
                                cnt_next = cnt + NB_DELAY'(1);
                            end
                        end
                        default: begin
                        end
                    endcase
                end
            end
        end
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            delay   <= '0;
            wr_ptr  <= '0;
            o_valid <= 1'b0;
        end else begin
            state   <= state_next;
            cnt     <= cnt_next;
            delay   <= delay_next;
            o_valid <= advance;
            if (advance) begin
                wr_ptr <= wr_ptr + NB_ADDR'(1);
            end
        end
    end

    // Reading with the updated delay lets a freshly measured value align the SOL on the lock cycle itself.
    assign rd_addr = wr_ptr - NB_ADDR'(delay_next);

    deskew_buffer_ram #(
        .NB_DATA (NB_CODED_BLOCK + 1),
        .NB_ADDR (NB_ADDR)
    ) u_buffer (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_wr_en (advance),
        .i_waddr (wr_ptr),
        .i_wdata ({i_start_of_lane, i_data}),
        .i_rd_en (advance),
        .i_raddr (rd_addr),
        .o_rdata ({o_start_of_lane, o_data})
    );

    assign o_deskew_done   = (state == ST_LOCKED);
    assign o_skew_overflow = (state == ST_OVERFLOW);
    assign o_delay         = delay;

endmodule
